// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit bridging the single-cycle datapath to a req/ack data-memory bus
// Ports:
//   clk_i, reset_i (async, active-high)
//   datapath in : mem_read_i, mem_write_i, funct3_i, alu_result_i, write_data_i
//   datapath out: read_data_o (valid in DONE), stall_o, misaligned_o
//   bus out     : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
//   bus in      : mem_ack_i, mem_rdata_i
module lsu_mem_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state_q;
  logic [1:0]  lane_q;
  logic        is_byte_q, is_half_q, uns_q;
  logic [31:0] rdata_q;
  logic        is_byte, is_half, access, aligned, go;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, rdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  // funct3[1:0] picks the size; 011/110/111 fall through to word
  assign is_byte      = funct3_i[1:0] == 2'b00;
  assign is_half      = funct3_i[1:0] == 2'b01;
  assign access       = mem_read_i | mem_write_i;
  assign aligned      = is_byte | (is_half ? ~alu_result_i[0] : alu_result_i[1:0] == 2'b00);
  assign go           = state_q == IDLE && access && aligned;
  assign stall_o      = go || state_q == REQ;
  assign misaligned_o = state_q == IDLE && access && !aligned;
  assign read_data_o  = state_q == DONE ? rdata_q : '0;
  always_comb begin
    be_d     = is_byte ? 4'b0001 << alu_result_i[1:0]
             : is_half ? (alu_result_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_d  = is_byte ? {4{write_data_i[7:0]}} : is_half ? {2{write_data_i[15:0]}} : write_data_i;
    byte_sel = mem_rdata_i[{lane_q, 3'b000} +: 8];
    half_sel = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];
    rdata_d  = is_byte_q ? {{24{~uns_q & byte_sel[7]}}, byte_sel}
             : is_half_q ? {{16{~uns_q & half_sel[15]}}, half_sel} : mem_rdata_i;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q     <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      lane_q      <= '0;
      is_byte_q   <= 1'b0;
      is_half_q   <= 1'b0;
      uns_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          state_q     <= REQ;
          mem_req_o   <= 1'b1;
          mem_we_o    <= mem_write_i;
          mem_addr_o  <= {alu_result_i[31:2], 2'b00};
          mem_wdata_o <= wdata_d;
          mem_be_o    <= be_d;
          lane_q      <= alu_result_i[1:0];
          is_byte_q   <= is_byte;
          is_half_q   <= is_half;
          uns_q       <= funct3_i[2];
        end
        REQ: if (mem_ack_i) begin
          state_q   <= DONE;
          mem_req_o <= 1'b0;
          // stores return nothing, so keep the writeback value clean
          rdata_q   <= mem_we_o ? '0 : rdata_d;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit between the single-cycle datapath and a handshaked data-memory bus. It takes the datapath's address (ALUResult) and store data (WriteData) and runs a req/ack transaction. It returns sign- or zero-extended load data on ReadData and holds the datapath with Stall until the access completes. Byte, half and word accesses are supported, with byte-enable generation and misalignment detection.

## Interface
- No parameters; all buses 32 bits.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store; wins if both high (MemRead ignored)
- Funct3  in  3  size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; 011/110/111 treated as word
- ALUResult  in  32  byte address
- WriteData  in  32  store data, right-aligned
- ReadData  out  32  formatted load data, valid while state=DONE
- Stall  out  1  datapath must hold PC/register file
- Misaligned  out  1  one-cycle flag, access rejected
- mem_req  out  1  bus request, registered
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  word address, {ALUResult[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  one-cycle completion strobe; mem_rdata valid with it
- mem_rdata  in  32  read word

## Operation
- FSM has three states: IDLE, REQ, DONE. Reset and default state is IDLE.
- Access = MemWrite | MemRead.
- Aligned rule:
  - byte: always aligned
  - half: ALUResult[0]=0
  - word: ALUResult[1:0]=00
- IDLE, access and aligned:
  - Stall=1 (combinational)
  - Register mem_addr, mem_we, mem_be, mem_wdata, load size/sign and ALUResult[1:0]
  - Set mem_req=1 and go to REQ
- IDLE, access and misaligned:
  - Misaligned=1, Stall=0, ReadData=0
  - No bus request; stay IDLE
  - The datapath retires the instruction; the store is suppressed
- REQ:
  - Stall=1; mem_req, mem_addr, mem_we, mem_be, mem_wdata held stable
  - On mem_ack=1: clear mem_req, capture formatted mem_rdata (loads only) into the ReadData register, go to DONE
- DONE:
  - Stall=0; ReadData drives the captured value for the load writeback
  - Unconditional return to IDLE, so the same instruction is never re-issued
- Byte enables and write data for byte lane k=ALUResult[1:0]:
  - byte: mem_be=1<<k, mem_wdata={4{WriteData[7:0]}}
  - half: mem_be=0011 (addr[1]=0) or 1100 (addr[1]=1), mem_wdata={2{WriteData[15:0]}}
  - word: mem_be=1111, mem_wdata=WriteData
- Load formatting:
  - Select byte mem_rdata[8k+7:8k], or half mem_rdata[16h+15:16h] with h=addr[1]
  - Sign-extend for 000/001; zero-extend for 100/101
- Reads drive mem_be per size as well; the memory may ignore them.
- mem_ack is ignored in IDLE and DONE.
- ReadData equals 0 outside DONE.

## Timing
- Reset values:
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0
  - ReadData register=0, Misaligned=0
  - Stall=0 unless an aligned access is presented
- Minimum latency: request seen in IDLE at cycle 0; mem_req=1 from cycle 1; ack in cycle 1 gives DONE in cycle 2. That is 3 cycles per access with Stall high for 2.
- Each wait cycle of mem_ack adds one REQ cycle; there is no timeout.
- mem_req deasserts on the clock edge following the ack cycle. Only one transaction is outstanding, and there is no back-to-back issue without an intervening IDLE cycle.
- Inputs MemRead/MemWrite/Funct3/ALUResult/WriteData are sampled only in IDLE. Changes during REQ or DONE are ignored.
- Reset mid-REQ:
  - mem_req drops immediately (asynchronously) and the FSM returns to IDLE
  - A late mem_ack after reset is ignored
- Misaligned is combinational in IDLE and lasts one cycle for a single-cycle instruction.

## Test plan
- lw at 0x100 with ack on the first REQ cycle and mem_rdata=0xDEADBEEF: mem_be=1111, mem_addr=0x100; Stall high 2 cycles; ReadData=0xDEADBEEF in DONE.
- lb at 0x103 with mem_rdata=0x80FF_FF00: mem_be=1000, ReadData=0xFFFFFF80. Same access as lbu gives ReadData=0x00000080.
- sh at 0x202 with WriteData=0x1234ABCD: mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
- sw with ack delayed 5 cycles: mem_req and bus fields stable for 6 REQ cycles; Stall high 7 cycles; DONE for exactly 1 cycle.
- lw at 0x101: Misaligned=1 for 1 cycle, mem_req stays 0, Stall=0. A lh at 0x103 behaves the same way.
- reset asserted during REQ, then ack arrives 2 cycles later: mem_req=0 immediately; state stays IDLE; ReadData=0.
